// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: drives the fetch PC, pairs cache responses with their PC and queues them for decode.
// Optional feature: define IFU_FQ_BYPASS_EN to let a response reach decode in the same cycle when the queue is empty.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pcQ100H,
    input  logic        ic_rsp_valid,
    input  logic [31:0] ic_rsp_pc,
    input  logic [31:0] ic_rsp_instr,
    input  logic        ic_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fq_valid,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_instr,
    input  logic        fq_ready
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] FULL    = CW'(FQ_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        RESET_WAIT,
        FETCH,
        WAIT_MISS,
        WAIT_Q
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   fetch_pc;
    logic [31:0]   exp_pc;
    logic          inflight;
    logic [31:0]   q_pc    [FQ_DEPTH];
    logic [31:0]   q_instr [FQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic space_ok;
    logic advance;
    logic push;
    logic q_push;
    logic q_pop;
    logic q_nonempty;
    logic bypass_hit;

    // A new request is issued only if a slot is reserved for it, counting the one still in flight.
    assign space_ok   = ({1'b0, count} + SW'(inflight) + SW'(1)) <= SW'(FQ_DEPTH);
    assign push       = ic_rsp_valid & inflight & (ic_rsp_pc == exp_pc) & ~redirect_valid;
    assign q_nonempty = (count != '0);
    assign q_pop      = q_nonempty & fq_ready & ~redirect_valid;

`ifdef IFU_FQ_BYPASS_EN
    assign bypass_hit = push & ~q_nonempty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign q_push  = push & ~(bypass_hit & fq_ready);
    assign pcQ100H = fetch_pc;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            state_nx = FETCH;
        end else begin
            unique case (state)
                RESET_WAIT: state_nx = FETCH;
                FETCH: begin
                    if (ic_stall) begin
                        state_nx = WAIT_MISS;
                    end else if (!space_ok) begin
                        state_nx = WAIT_Q;
                    end
                end
                WAIT_MISS: if (!ic_stall) state_nx = FETCH;
                WAIT_Q:    if (space_ok)  state_nx = FETCH;
                default:   state_nx = FETCH;
            endcase
        end
    end

    always_comb begin
        advance = (state == FETCH) & ~ic_stall & space_ok & ~redirect_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            exp_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else if (advance) begin
            fetch_pc <= fetch_pc + 32'd4;
            exp_pc   <= fetch_pc;
            inflight <= 1'b1;
        end else if (push) begin
            inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (q_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (q_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({q_push, q_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; the head is only exposed while count says it holds data.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc[wr_ptr]    <= ic_rsp_pc;
            q_instr[wr_ptr] <= ic_rsp_instr;
        end
    end

    always_comb begin
        fq_valid = q_nonempty;
        fq_pc    = '0;
        fq_instr = '0;
        if (q_nonempty) begin
            fq_pc    = q_pc[rd_ptr];
            fq_instr = q_instr[rd_ptr];
        end
`ifdef IFU_FQ_BYPASS_EN
        else if (bypass_hit) begin
            fq_valid = 1'b1;
            fq_pc    = ic_rsp_pc;
            fq_instr = ic_rsp_instr;
        end
`endif
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && count == FULL));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: table-driven startup/miss stream plus hand-written
// backpressure, redirect, simultaneous-event and wrap/async-reset sequences.
module tb_ifu_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_rsp_valid = 1'b0;
    logic [31:0] ic_rsp_pc = '0;
    logic [31:0] ic_rsp_instr = '0;
    logic        ic_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fq_ready = 1'b1;
    logic [31:0] pcQ100H;
    logic        fq_valid;
    logic [31:0] fq_pc;
    logic [31:0] fq_instr;

    logic        w_rst = 1'b1;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_pc = '0;
    logic [31:0] w_rsp_instr = '0;
    logic        w_stall = 1'b0;
    logic [31:0] w_pc;
    logic        w_fq_valid;
    logic [31:0] w_fq_pc;
    logic [31:0] w_fq_instr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] miss_pc = 32'h0000_000C;
    logic        miss_armed = 1'b1;
    int          stall_left = 0;

    typedef struct {
        logic        ready;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] head_pc;
    } vec_t;

    vec_t vecs [15];

    ifu_fetch_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .pcQ100H        (pcQ100H),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_pc      (ic_rsp_pc),
        .ic_rsp_instr   (ic_rsp_instr),
        .ic_stall       (ic_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_valid       (fq_valid),
        .fq_pc          (fq_pc),
        .fq_instr       (fq_instr),
        .fq_ready       (fq_ready)
    );

    ifu_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst            (w_rst),
        .pcQ100H        (w_pc),
        .ic_rsp_valid   (w_rsp_valid),
        .ic_rsp_pc      (w_rsp_pc),
        .ic_rsp_instr   (w_rsp_instr),
        .ic_stall       (w_stall),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .fq_valid       (w_fq_valid),
        .fq_pc          (w_fq_pc),
        .fq_instr       (w_fq_instr),
        .fq_ready       (1'b0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: the cache model answers next cycle for any PC it saw while not stalled,
    // except the armed miss PC, which stalls for 5 cycles and then returns.
    task automatic cycle();
        logic [31:0] seen_pc;
        logic        seen_acc;
        seen_pc  = pcQ100H;
        seen_acc = !ic_stall;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        ic_rsp_valid   = 1'b0;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin
                ic_stall     = 1'b0;
                ic_rsp_valid = 1'b1;
                ic_rsp_pc    = miss_pc;
                ic_rsp_instr = instr_of(miss_pc);
            end
        end else if (seen_acc) begin
            if (miss_armed && seen_pc == miss_pc) begin
                miss_armed = 1'b0;
                ic_stall   = 1'b1;
                stall_left = 5;
            end else begin
                ic_rsp_valid = 1'b1;
                ic_rsp_pc    = seen_pc;
                ic_rsp_instr = instr_of(seen_pc);
            end
        end
        #1;
    endtask

    task automatic restart(input logic ready);
        rst        = 1'b0;
        stall_left = 0;
        ic_stall   = 1'b0;
        miss_armed = 1'b0;
        fq_ready   = ready;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Startup stream with a 5-cycle miss on the request for 0xC (0x10 sits on the bus meanwhile).
        vecs[0]  = '{1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3]  = '{1'b1, 32'h08, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[5]  = '{1'b1, 32'h10, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 32'h10, 1'b0, 32'h00};
        vecs[7]  = '{1'b1, 32'h10, 1'b0, 32'h00};
        vecs[8]  = '{1'b1, 32'h10, 1'b0, 32'h00};
        vecs[9]  = '{1'b1, 32'h10, 1'b0, 32'h00};
        vecs[10] = '{1'b1, 32'h10, 1'b0, 32'h00};
        vecs[11] = '{1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[12] = '{1'b1, 32'h14, 1'b0, 32'h00};
        vecs[13] = '{1'b1, 32'h18, 1'b1, 32'h10};
        vecs[14] = '{1'b1, 32'h1C, 1'b1, 32'h14};

        #1;
        rst   = 1'b0;
        w_rst = 1'b0;
        cycle();
        cycle();
        check("reset pc", pcQ100H, 32'h0);
        check("reset fq_valid", 32'(fq_valid), 32'h0);
        check("reset fq_pc", fq_pc, 32'h0);
        check("reset fq_instr", fq_instr, 32'h0);
        check("wrap reset pc", w_pc, 32'hFFFF_FFF8);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            fq_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d pc", i), pcQ100H, vecs[i].pc);
            check($sformatf("vec%0d fq_valid", i), 32'(fq_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                check($sformatf("vec%0d fq_pc", i), fq_pc, vecs[i].head_pc);
                check($sformatf("vec%0d fq_instr", i), fq_instr, instr_of(vecs[i].head_pc));
            end
            cycle();
        end

        // Backpressure from reset: four entries buffered, head held at 0x0, fetch parked at 0x10.
        restart(1'b0);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("bp%0d pc", k), pcQ100H,
                  (k < 2) ? 32'h0 : (k < 5) ? 32'(4 * (k - 1)) : 32'h10);
            if (k >= 3) begin
                check($sformatf("bp%0d fq_valid", k), 32'(fq_valid), 32'h1);
                check($sformatf("bp%0d fq_pc", k), fq_pc, 32'h0);
            end
            cycle();
        end
        fq_ready = 1'b1;
        for (int d = 0; d < 5; d++) begin
            #1;
            check($sformatf("drain%0d pc", d), pcQ100H,
                  (d < 3) ? 32'h10 : 32'(32'h10 + 4 * (d - 2)));
            check($sformatf("drain%0d fq_valid", d), 32'(fq_valid), 32'h1);
            check($sformatf("drain%0d fq_pc", d), fq_pc, 32'(4 * d));
            cycle();
        end

        // Redirect to 0x203 in the cycle the 0x8 response arrives; two entries queued.
        restart(1'b0);
        for (int k = 0; k < 4; k++) cycle();
        check("pre-redirect fq_valid", 32'(fq_valid), 32'h1);
        check("pre-redirect fq_pc", fq_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        cycle();
        check("redirect pc", pcQ100H, 32'h200);
        check("redirect flush fq_valid", 32'(fq_valid), 32'h0);
        fq_ready = 1'b1;
        cycle();
        check("redirect+1 pc", pcQ100H, 32'h204);
        check("redirect+1 fq_valid", 32'(fq_valid), 32'h0);
        cycle();
        check("redirect+2 fq_valid", 32'(fq_valid), 32'h1);
        check("first target fq_pc", fq_pc, 32'h200);
        check("first target fq_instr", fq_instr, instr_of(32'h200));
        cycle();

        // Redirect, push of 0x208 and pop of 0x204 all in one cycle.
        check("simul head fq_pc", fq_pc, 32'h204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        cycle();
        check("simul count", 32'(u_dut.count), 32'h0);
        check("simul fq_valid", 32'(fq_valid), 32'h0);
        check("simul pc", pcQ100H, 32'h400);
        cycle();
        check("simul+1 fq_valid", 32'(fq_valid), 32'h0);
        cycle();
        check("simul+2 fq_valid", 32'(fq_valid), 32'h1);
        check("simul+2 fq_pc", fq_pc, 32'h400);

        // Wrap from 0xFFFF_FFF8, then async reset while a miss is pending.
        w_rst = 1'b1;
        check("wrap e0 pc", w_pc, 32'hFFFF_FFF8);
        cycle();
        check("wrap e1 pc", w_pc, 32'hFFFF_FFF8);
        cycle();
        check("wrap e2 pc", w_pc, 32'hFFFF_FFFC);
        w_rsp_valid = 1'b1;
        w_rsp_pc    = 32'hFFFF_FFF8;
        w_rsp_instr = instr_of(32'hFFFF_FFF8);
        cycle();
        check("wrap e3 pc", w_pc, 32'h0);
        w_rsp_pc    = 32'hFFFF_FFFC;
        w_rsp_instr = instr_of(32'hFFFF_FFFC);
        cycle();
        w_rsp_valid = 1'b0;
        w_stall     = 1'b1;
        #1;
        check("wrap e4 fq_valid", 32'(w_fq_valid), 32'h1);
        check("wrap e4 fq_pc", w_fq_pc, 32'hFFFF_FFF8);
        cycle();
        check("wrap miss hold pc", w_pc, 32'h4);
        w_rst = 1'b0;
        #1;
        check("async reset pc", w_pc, 32'hFFFF_FFF8);
        check("async reset fq_valid", 32'(w_fq_valid), 32'h0);
        check("async reset fq_pc", w_fq_pc, 32'h0);
        check("async reset fq_instr", w_fq_instr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Fetch controller directly upstream of `ifu`. It generates the fetch PC (`pcQ100H`) and holds it while the instruction cache reports a miss. It pairs each returned instruction with its PC and buffers the pair in a small fetch queue, which decode drains with a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FQ_DEPTH`, default 4: fetch-queue entries; must be a power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pcQ100H`  out  32  fetch PC presented to `ifu`.
- `ic_rsp_valid`  in  1  cache returns an instruction this cycle.
- `ic_rsp_pc`  in  32  PC echoed with the response.
- `ic_rsp_instr`  in  32  fetched instruction.
- `ic_stall`  in  1  miss pending; cache cannot accept a new PC.
- `redirect_valid`  in  1  core redirect (taken branch, jump, trap).
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `fq_valid`  out  1  queue head valid toward decode.
- `fq_pc` / `fq_instr`  out  32 / 32  head PC and instruction.
- `fq_ready`  in  1  decode accepts the head.

## Operation
- **State: `fetch_pc`**, which drives `pcQ100H`.
- **State: `exp_pc`**, the PC of the oldest outstanding request.
- **State: `inflight`**, 0 or 1.
- **State: queue**, `FQ_DEPTH` entries of {pc, instr}, with `wr_ptr`/`rd_ptr` and `count` of width clog2(FQ_DEPTH+1).
- **FSM `RESET_WAIT`:** entered on reset. Leaves for `FETCH` on the first clock edge with rst high.
- **FSM `FETCH`:**
  - Compute `advance = ~ic_stall & (count + inflight + 1 <= FQ_DEPTH)`.
  - On advance: `fetch_pc <= fetch_pc + 4`, `inflight <= 1`, `exp_pc <= fetch_pc`.
  - Go to `WAIT_MISS` when `ic_stall` is 1.
  - Go to `WAIT_Q` when the space check fails.
- **FSM `WAIT_MISS`:** hold `fetch_pc`. Return to `FETCH` when `ic_stall` falls.
- **FSM `WAIT_Q`:** hold `fetch_pc`. Return to `FETCH` when the space check passes.
- **Push:** requires `ic_rsp_valid & inflight & (ic_rsp_pc == exp_pc) & ~redirect_valid`. A push clears `inflight` unless the same cycle advances.
- **Drop:** a response with a mismatched PC, or one arriving with `inflight == 0`, is silently dropped.
- **Pop:** `fq_valid & fq_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect:** has highest priority, from any state.
  - Next cycle: `fetch_pc = redirect_pc & ~3`, `count = 0`, pointers = 0, `inflight = 0`, FSM = `FETCH`.
  - A same-cycle pop or push is discarded.
- **Arithmetic:** the PC increments modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. Pointers wrap modulo `FQ_DEPTH`.
- **Overflow:** the reservation rule makes overflow impossible. A simulation assertion fires if a push occurs with `count == FQ_DEPTH`.

## Timing
- **Reset values:**
  - `pcQ100H` = `RESET_PC`.
  - `fq_valid` = 0, `fq_pc` = 0, `fq_instr` = 0.
  - Internal: `inflight` = 0, `count` = 0, FSM = `RESET_WAIT`.
- **Cache contract:** a hit for the PC presented in cycle N returns `ic_rsp_valid` in cycle N+1. On a miss, `ic_stall` is high from N+1 until the cycle the response is returned.
- **Throughput:** one instruction per cycle while hitting and decode is ready.
- **Latency:** response to `fq_valid` is 1 cycle, since the queue is registered. The bypass option reduces this to 0.
- **Redirect to bus:** redirect in cycle N puts the target on `pcQ100H` in N+1. The first target instruction is visible at decode at N+3 without bypass, N+2 with bypass.
- **Reset mid-operation:** asynchronous assertion returns all state to the reset values immediately. Any in-flight response is then dropped because `inflight = 0`.
- **Handshake rule:** `fq_pc`/`fq_instr` must stay stable while `fq_valid & ~fq_ready`.

## Configuration
- **`IFU_FQ_BYPASS_EN` defined:** when `count == 0` and a push is legal, the response drives `fq_valid`/`fq_pc`/`fq_instr` combinationally in the same cycle.
  - If `fq_ready` is also 1, the entry is not written to the queue.
  - Otherwise it is written as normal.
- **Not defined:** all outputs come from queue registers; no combinational path from `ic_rsp_*` to `fq_*`.

## Test plan
- **Reset release:** release reset, with hits and `fq_ready=1`.
  - Required: `pcQ100H` reads 0x0, 0x4, 0x8, … one per cycle.
  - Required: decode receives {0x0, i0}, {0x4, i1} in consecutive cycles, with latency 1, or 0 with bypass.
- **Miss:** `ic_stall` high 5 cycles on PC 0x10.
  - Required: `pcQ100H` holds 0x10.
  - Required: after the response the next PC is 0x14, with no duplicate or lost entries.
- **Backpressure:** `fq_ready=0` from reset.
  - Required: exactly 4 entries (0x0–0xC) are buffered.
  - Required: `pcQ100H` stalls at 0x10, `fq_pc` stays 0x0 and stable, and no assertion fires.
- **Redirect with stale response:** redirect to 0x203 while the response for 0x8 is in flight.
  - Required: the 0x8 response is dropped and the queue is emptied.
  - Required: `pcQ100H` = 0x200 next cycle, and the first dequeued pc = 0x200.
- **Simultaneous events:** assert redirect, push and pop in the same cycle.
  - Required: the flush wins, `count` = 0 next cycle, and the popped entry is not reissued.
- **Wrap and async reset:** start at `RESET_PC` = 0xFFFF_FFF8.
  - Required: the PC sequence is FFFF_FFF8, FFFF_FFFC, 0x0.
  - Then assert `rst` mid-miss: all outputs return to reset values with no clock edge.
